// File: rtl/seg_display_ctrl.sv
// Multi-digit 7-segment display controller: hex or decimal (sequential double-dabble)
// presentation with leading-zero blanking, overflow dashes and whole-display blinking.
module seg_display_ctrl #(
  parameter int DIGITS    = 4,
  parameter int DATA_W    = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [DATA_W-1:0]     Data,
  input  logic                  Mode,
  input  logic                  Blank_lz,
  input  logic                  Blink_en,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Overflow,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned DEC_MAX = pow10(DIGITS) - 1;

  // Active-low glyphs, bit0 = segment a .. bit6 = segment g.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic                ovf_q, ovf_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                done_q, done_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic                phase_q, phase_d;

  logic [63:0]         data_ext;
  logic                hex_ovf, dec_ovf;
  logic [DW-1:0]       adj;
  logic [7*DIGITS-1:0] hex_new;

  assign data_ext = 64'(Data);
  assign hex_ovf  = |(data_ext >> DW);
  assign dec_ovf  = data_ext > DEC_MAX;

  // Glyph image built from the digit register; only latched into hex_q at UPDATE.
  always_comb begin : glyph_p
    logic       lead_zero;
    logic [3:0] nib;
    lead_zero = 1'b1;
    nib       = '0;
    hex_new   = '1;
    for (int unsigned k = DIGITS; k > 0; k--) begin
      nib       = dig_q[4*(k-1) +: 4];
      lead_zero = lead_zero & (nib == 4'd0);
      if (ovf_pend_q)
        hex_new[7*(k-1) +: 7] = SEG_DASH;
      else if (Blank_lz && lead_zero && (k != 1))
        hex_new[7*(k-1) +: 7] = SEG_BLANK;
      else
        hex_new[7*(k-1) +: 7] = seg7(nib);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    dig_d      = dig_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    hex_d      = hex_q;
    adj        = dig_q;
    done_d     = (state_q == UPDATE);
    case (state_q)
      IDLE: begin
        if (Load) begin
          bin_d      = Data;
          cnt_d      = '0;
          ovf_pend_d = Mode ? dec_ovf : hex_ovf;
          if (Mode) begin
            dig_d   = '0;
            state_d = CONV;
          end else begin
            dig_d   = data_ext[DW-1:0];
            state_d = UPDATE;
          end
        end
      end
      CONV: begin
        // Add-3 correction then a joint left shift of the BCD:binary pair.
        for (int unsigned i = 0; i < DIGITS; i++)
          if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        {dig_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        ovf_d   = ovf_pend_q;
        hex_d   = hex_new;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcnt_d  = bcnt_q + BW'(1);
    phase_d = phase_q;
    if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      dig_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      hex_q      <= '1;
      done_q     <= 1'b0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      dig_q      <= dig_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      hex_q      <= hex_d;
      done_q     <= done_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
    end
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign Overflow = ovf_q;
  assign HEX      = (Blink_en && phase_q) ? '1 : hex_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with DIGITS=4, DATA_W=16, BLINK_DIV=8.
module tb_seg_display_ctrl;

  logic        Clock = 1'b0;
  logic        Reset, Load, Mode, Blank_lz, Blink_en;
  logic [15:0] Data;
  logic        Busy, Done, Overflow;
  logic [27:0] HEX;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;
  int unsigned n        = 0;
  int unsigned done_cnt = 0;

  localparam logic [27:0] ALL1     = 28'hFFFFFFF;
  localparam logic [27:0] G_BEEF   = {7'h03, 7'h06, 7'h06, 7'h0E};
  localparam logic [27:0] G_9999   = {7'h10, 7'h10, 7'h10, 7'h10};
  localparam logic [27:0] G_DASH   = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
  localparam logic [27:0] G_42LZ   = {7'h7F, 7'h7F, 7'h19, 7'h24};
  localparam logic [27:0] G_0LZ    = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] G_A5LZ   = {7'h7F, 7'h7F, 7'h08, 7'h12};
  localparam logic [27:0] G_1234   = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] G_5678   = {7'h12, 7'h02, 7'h78, 7'h00};

  seg_display_ctrl #(.DIGITS(4), .DATA_W(16), .BLINK_DIV(8)) dut (
    .Clock(Clock), .Reset(Reset), .Load(Load), .Data(Data), .Mode(Mode),
    .Blank_lz(Blank_lz), .Blink_en(Blink_en), .Busy(Busy), .Done(Done),
    .Overflow(Overflow), .HEX(HEX)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    n++;
    if (Done) done_cnt++;
  endtask

  task automatic load(input logic [15:0] d, input logic m);
    Data = d;
    Mode = m;
    Load = 1'b1;
    tick();
    Load = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Load = 1'b0; Mode = 1'b0; Data = '0;
    Blank_lz = 1'b0; Blink_en = 1'b0;
    @(posedge Clock); #1;
    chk("rst_hex", 32'(HEX), 32'(ALL1));
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_ovf", 32'(Overflow), 0);
    Reset = 1'b0; n = 0;

    // hex BEEF: one cycle latency
    load(16'hBEEF, 1'b0);
    chk("beef_busy", 32'(Busy), 1);
    chk("beef_hold", 32'(HEX), 32'(ALL1));
    chk("beef_nodone", 32'(Done), 0);
    tick();
    chk("beef_hex", 32'(HEX), 32'(G_BEEF));
    chk("beef_done", 32'(Done), 1);
    chk("beef_idle", 32'(Busy), 0);
    chk("beef_ovf", 32'(Overflow), 0);
    tick();
    chk("beef_done_end", 32'(Done), 0);

    // decimal 9999: DATA_W+1 latency
    load(16'd9999, 1'b1);
    repeat (16) tick();
    chk("d9999_busy", 32'(Busy), 1);
    chk("d9999_hold", 32'(HEX), 32'(G_BEEF));
    tick();
    chk("d9999_hex", 32'(HEX), 32'(G_9999));
    chk("d9999_done", 32'(Done), 1);
    chk("d9999_idle", 32'(Busy), 0);
    chk("d9999_ovf", 32'(Overflow), 0);

    // decimal 10000 overflows even with blanking on
    Blank_lz = 1'b1;
    load(16'd10000, 1'b1);
    repeat (17) tick();
    chk("d10000_ovf", 32'(Overflow), 1);
    chk("d10000_hex", 32'(HEX), 32'(G_DASH));

    load(16'd42, 1'b1);
    repeat (17) tick();
    chk("d42_hex", 32'(HEX), 32'(G_42LZ));
    chk("d42_ovf", 32'(Overflow), 0);
    load(16'd0, 1'b1);
    repeat (17) tick();
    chk("d0_hex", 32'(HEX), 32'(G_0LZ));
    load(16'h00A5, 1'b0);
    repeat (2) tick();
    chk("hA5_hex", 32'(HEX), 32'(G_A5LZ));
    Blank_lz = 1'b0;

    // reset in the middle of a conversion
    load(16'd1234, 1'b1);
    repeat (5) tick();
    Reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(Busy), 0);
    chk("midrst_hex", 32'(HEX), 32'(ALL1));
    chk("midrst_done", 32'(Done), 0);
    @(posedge Clock); #1;
    Reset = 1'b0; n = 0; done_cnt = 0;
    repeat (20) tick();
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_hex_kept", 32'(HEX), 32'(ALL1));
    load(16'd1234, 1'b1);
    repeat (17) tick();
    chk("d1234_hex", 32'(HEX), 32'(G_1234));
    chk("d1234_done", 32'(Done), 1);

    // loads during a conversion are ignored
    repeat (2) tick();
    done_cnt = 0;
    load(16'd5678, 1'b1);
    Data = 16'h1111; Mode = 1'b0; Load = 1'b1;
    tick();
    Load = 1'b0;
    repeat (3) tick();
    Data = 16'h2222; Mode = 1'b1; Load = 1'b1;
    tick();
    Load = 1'b0;
    repeat (12) tick();
    chk("d5678_hex", 32'(HEX), 32'(G_5678));
    chk("d5678_done", 32'(Done), 1);
    chk("d5678_idle", 32'(Busy), 0);
    repeat (5) tick();
    chk("d5678_one_done", done_cnt, 1);
    chk("d5678_hex_kept", 32'(HEX), 32'(G_5678));

    // blinking: phase toggles every 8 edges after reset release
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0; n = 0;
    load(16'h1234, 1'b0);
    tick();
    Blink_en = 1'b1;
    #1;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("blink", 32'(HEX), ((n / 8) % 2 == 1) ? 32'(ALL1) : 32'(G_1234));
    end
    for (int i = 0; i < 8; i++)
      if ((n / 8) % 2 == 0) tick();
    chk("blink_mid_blank", 32'(HEX), 32'(ALL1));
    Blink_en = 1'b0;
    #1;
    chk("blink_off_now", 32'(HEX), 32'(G_1234));
    tick();
    chk("blink_off_next", 32'(HEX), 32'(G_1234));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
